// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - prefetching instruction fetch unit with branch redirect and flush
// Optional feature macro: FETCH_BYPASS_EN (forward a response straight to decode when the buffer is empty)
module instruction_fetch_unit #(
    parameter int                 BITSIZE    = 32,
    parameter int                 FIFO_DEPTH = 4,
    parameter logic [BITSIZE-1:0] RESET_ADDR = '0
) (
    input  logic               clk,
    input  logic               resetn_i,
    input  logic               fetch_next_i,
    output logic [31:0]        instruction_o,
    output logic [BITSIZE-1:0] pc_o,
    output logic               fetch_valid_o,
    input  logic               branch_i,
    input  logic [BITSIZE-1:0] branch_addr_i,
    output logic               mem_req_o,
    output logic [BITSIZE-1:0] mem_addr_o,
    input  logic               mem_gnt_i,
    input  logic               mem_rvalid_i,
    input  logic [31:0]        mem_rdata_i
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int OW = PW + 2;
    localparam logic [BITSIZE-1:0] WORD_MASK  = ~(BITSIZE'(3));
    localparam logic [BITSIZE-1:0] START_ADDR = RESET_ADDR & WORD_MASK;
    localparam logic [BITSIZE-1:0] STEP       = BITSIZE'(4);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t             state_q;
    logic [BITSIZE-1:0] addr_q;
    logic [BITSIZE-1:0] tgt_q;
    logic               tgt_pend_q;
    logic               req_hold_q;
    logic [BITSIZE-1:0] resp_pc_q;
    logic [OW-1:0]      outst_q;
    logic [OW-1:0]      drop_q;

    logic [31:0]        data_mem [FIFO_DEPTH];
    logic [BITSIZE-1:0] pc_mem   [FIFO_DEPTH];
    logic [PW-1:0]      rd_ptr_q;
    logic [PW-1:0]      wr_ptr_q;
    logic [CW-1:0]      count_q;

    logic               room;
    logic               grant;
    logic               req_stall;
    logic               dropping;
    logic               keep;
    logic               fifo_empty;
    logic               bypass;
    logic               consume;
    logic               fifo_push;
    logic               fifo_pop;
    logic [BITSIZE-1:0] target;
    logic [OW-1:0]      outst_next;
    logic [OW-1:0]      outst_after_resp;
    logic [OW-1:0]      drop_load;
    logic [OW-1:0]      drop_next;

    assign target     = branch_addr_i & WORD_MASK;
    assign fifo_empty = (count_q == '0);

    // Buffered entries plus in-flight requests never exceed the buffer, so rvalid needs no back-pressure.
    assign room       = (OW'(count_q) + outst_q) < OW'(FIFO_DEPTH);
    assign mem_req_o  = req_hold_q || ((state_q == FETCH) && room);
    assign mem_addr_o = addr_q;
    assign grant      = mem_req_o && mem_gnt_i;
    assign req_stall  = mem_req_o && !mem_gnt_i;

    assign dropping   = mem_rvalid_i && (drop_q != '0);
    assign keep       = mem_rvalid_i && (drop_q == '0) && !branch_i;

`ifdef FETCH_BYPASS_EN
    assign bypass     = keep && fifo_empty;
`else
    assign bypass     = 1'b0;
`endif

    assign fetch_valid_o = !fifo_empty || bypass;
    assign consume       = fetch_valid_o && fetch_next_i && !branch_i;
    assign fifo_pop      = consume && !fifo_empty;
    assign fifo_push     = keep && !(bypass && consume);

    always_comb begin
        instruction_o = '0;
        pc_o          = '0;
        if (!fifo_empty) begin
            instruction_o = data_mem[rd_ptr_q];
            pc_o          = pc_mem[rd_ptr_q];
        end else if (bypass) begin
            instruction_o = mem_rdata_i;
            pc_o          = resp_pc_q;
        end
    end

    assign outst_next       = outst_q + OW'(grant) - OW'(mem_rvalid_i);
    assign outst_after_resp = outst_q - OW'(mem_rvalid_i);
    // Everything already granted plus a stalled request belongs to the old path.
    assign drop_load        = outst_next + OW'(req_stall);

    always_comb begin
        drop_next = drop_q;
        if (branch_i) begin
            drop_next = drop_load;
        end else if (dropping) begin
            drop_next = drop_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q    <= IDLE;
            addr_q     <= START_ADDR;
            tgt_q      <= '0;
            tgt_pend_q <= 1'b0;
            req_hold_q <= 1'b0;
            resp_pc_q  <= START_ADDR;
            outst_q    <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            outst_q    <= outst_next;
            drop_q     <= drop_next;
            req_hold_q <= req_stall;

            if (grant) begin
                if (tgt_pend_q) begin
                    addr_q     <= tgt_q;
                    tgt_pend_q <= 1'b0;
                end else begin
                    addr_q <= addr_q + STEP;
                end
            end

            // A stalled request keeps its old address; the new target is parked until it is granted.
            if (branch_i) begin
                resp_pc_q <= target;
                if (req_stall) begin
                    tgt_q      <= target;
                    tgt_pend_q <= 1'b1;
                end else begin
                    addr_q     <= target;
                    tgt_pend_q <= 1'b0;
                end
            end else if (keep) begin
                resp_pc_q <= resp_pc_q + STEP;
            end

            if (branch_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (fifo_push) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
                if (fifo_pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                count_q <= count_q + CW'(fifo_push) - CW'(fifo_pop);
            end

            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                end
                FETCH: begin
                    if (branch_i && (outst_after_resp != '0)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drop_next == '0) begin
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            data_mem[wr_ptr_q] <= mem_rdata_i;
            pc_mem[wr_ptr_q]   <= resp_pc_q;
        end
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Parametrised successor of the single-shot fetch stage.
- Issues sequential instruction fetches to an instruction memory port using a req/gnt/rvalid handshake, and buffers returned words in a prefetch FIFO.
- Presents buffered instructions, each with its PC, to decode through a valid/next handshake.
- Supports branch redirect with flush; in-flight responses from the old path are discarded.

Parameters:
- BITSIZE, 32, address/PC width in bits (>= 3).
- FIFO_DEPTH, 4, prefetch buffer entries; power of two, 2..16.
- RESET_ADDR, 0, first fetch address after reset; bits [1:0] forced to 0.

Ports:
- clk  input  1  clock, all state on rising edge.
- resetn_i  input  1  asynchronous, active-low reset.
- fetch_next_i  input  1  decode consumes head entry when fetch_valid_o=1.
- instruction_o  output  32  head instruction.
- pc_o  output  BITSIZE  address of instruction_o.
- fetch_valid_o  output  1  head entry valid.
- branch_i  input  1  redirect request, single-cycle pulse.
- branch_addr_i  input  BITSIZE  redirect target; bits [1:0] ignored.
- mem_req_o  output  1  memory request.
- mem_addr_o  output  BITSIZE  request address, word aligned.
- mem_gnt_i  input  1  request accepted this cycle.
- mem_rvalid_i  input  1  response data valid.
- mem_rdata_i  input  32  response data.

Behaviour:
- Reset values: mem_req_o=0, mem_addr_o=RESET_ADDR, fetch_valid_o=0, instruction_o=0, pc_o=0. FIFO is empty, outstanding=0, drop=0, state=IDLE.
- FSM IDLE -> FETCH: unconditional, one cycle after reset release.
- FSM FETCH -> DRAIN: on branch_i while (outstanding - responses this cycle) > 0.
- FSM DRAIN -> FETCH: when drop reaches 0.
- Branch with no responses pending: stays in FETCH; new target fetched the next cycle.
- Memory protocol:
  - A request is granted on the cycle mem_req_o && mem_gnt_i.
  - Once raised, mem_req_o and mem_addr_o are held stable until granted.
  - Responses return in order, one per grant, at least 1 cycle after the grant.
- Issue rule: mem_req_o is raised in FETCH only if fifo_count + outstanding < FIFO_DEPTH. Every response therefore has a free slot; no back-pressure on rvalid.
- On a grant, mem_addr_o advances by 4 and wraps modulo 2^BITSIZE.
- Redirect (branch_i=1):
  - FIFO is flushed the same cycle; fetch_valid_o=0 the next cycle.
  - Fetch address becomes {branch_addr_i[BITSIZE-1:2],2'b00}.
  - drop is loaded with the outstanding count, plus 1 if a request is pending ungranted. That pending request is still held until granted; its response is discarded.
  - Each rvalid decrements drop while drop>0; such data is never written to the FIFO.
  - No new requests are issued in DRAIN.
  - A consume on the redirect cycle is ignored.
- Branch in DRAIN: drop recomputed as above, target replaced.
- FIFO:
  - rvalid with drop=0 writes {addr,data}; the stored PC tracks responses separately from mem_addr_o.
  - Head is consumed when fetch_valid_o && fetch_next_i.
  - Simultaneous write and consume at full or empty is legal and count is unchanged.
  - fetch_next_i with fetch_valid_o=0 has no effect.
- Latency, macro off: rvalid in cycle N gives fetch_valid_o=1 in cycle N+1.
- Reset asserted mid-operation clears everything immediately; the memory is reset by the same reset.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: when the FIFO is empty, drop=0 and mem_rvalid_i=1, then mem_rdata_i and its PC drive instruction_o/pc_o combinationally with fetch_valid_o=1 the same cycle. If fetch_next_i=1 that cycle, the word is not written to the FIFO; otherwise it is written.
- Undefined: all data passes through the FIFO (1-cycle latency).

Test Plan:
- Reset release with gnt=1 and rvalid one cycle after each grant, fetch_next_i=1 -> addrs 0x0,0x4,0x8,0xC issued back-to-back; pc_o 0x0,0x4,... each with the matching instruction.
- fetch_next_i=0, memory always grants -> exactly 4 grants (FIFO_DEPTH=4); mem_req_o stays 0 thereafter; one consume -> one new request.
- mem_gnt_i held 0 for 5 cycles -> mem_req_o=1 and mem_addr_o constant throughout; grant on cycle 6 -> addr advances by 4.
- 2 responses outstanding, branch_i with branch_addr_i=0x103 -> next 2 rvalids dropped; first request to 0x100; pc_o=0x100 is the first valid output.
- RESET_ADDR=0xFFFFFFF8, BITSIZE=32 -> fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
- FETCH_BYPASS_EN defined, FIFO empty, rvalid in cycle N -> fetch_valid_o=1 in cycle N; undefined -> in cycle N+1.
